// File: rtl/cpu_bus_frontend_pkg.sv
// Shared definitions for the 6502 bus front end: mode and access-phase
// encodings, the vector offset and the default overlay page.
package cpu_bus_frontend_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL  = 2'd0,
    MODE_ARMED   = 2'd1,
    MODE_OVERLAY = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_STROBE,
    ACC_CAPTURE,
    ACC_DRIVE,
    ACC_HOLD,
    ACC_WRITE
  } acc_e;

  localparam logic [7:0] VECTOR_OFFSET        = 8'hFA;
  localparam logic [7:0] OVERLAY_PAGE_DEFAULT = 8'hFF;

  // True for the NMI vector pair xxFA/xxFB.
  function automatic logic is_vector_offset(input logic [7:0] off);
    return off[7:1] == VECTOR_OFFSET[7:1];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-cycle rise/fall pulses for an already-synchronized level.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/cpu_bus_frontend.sv
// 6502 bus front end: synchronizes phi2, decodes accesses to the overlay
// page according to the debug mode, and strobes a clk-domain control window.
module cpu_bus_frontend
  import cpu_bus_frontend_pkg::*;
#(
  parameter logic [7:0]  OVERLAY_PAGE = OVERLAY_PAGE_DEFAULT,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phi2,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_sync,
  input  logic        nmi_n,
  input  logic [7:0]  ctrl_rdata,
  output logic [7:0]  A,
  output logic        csP,
  output logic        write,
  output logic [7:0]  ctrl_wdata,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        overlay
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 2);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYCLES);

  logic r_phi2_s1, r_phi2_s2;
  logic r_rw_s1, r_rw_s2;
  logic r_sync_s1, r_sync_s2;
  logic r_phi2_armed;
  logic [7:0] r_din;

  mode_e r_mode, w_mode_nxt;
  acc_e  r_acc, w_acc_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;

  logic w_rise_raw, w_rise, w_fall;
  logic w_page_hit, w_routed;
  logic w_csp_nxt, w_write_nxt, w_oe_nxt;
  logic w_latch, w_cap_rdata, w_cap_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phi2_s1    <= 1'b0;
      r_phi2_s2    <= 1'b0;
      r_rw_s1      <= 1'b0;
      r_rw_s2      <= 1'b0;
      r_sync_s1    <= 1'b0;
      r_sync_s2    <= 1'b0;
      r_phi2_armed <= 1'b0;
    end else begin
      r_phi2_s1 <= phi2;
      r_phi2_s2 <= r_phi2_s1;
      r_rw_s1   <= cpu_rw;
      r_rw_s2   <= r_rw_s1;
      r_sync_s1 <= cpu_sync;
      r_sync_s2 <= r_sync_s1;
      // A phi2 already high when reset lifts must not look like a new access.
      if (!r_phi2_s2) r_phi2_armed <= 1'b1;
    end
  end

  edge_detect u_phi2_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (r_phi2_s2),
    .o_rise (w_rise_raw),
    .o_fall (w_fall)
  );

  assign w_rise     = w_rise_raw & r_phi2_armed;
  assign w_page_hit = (cpu_addr[15:8] == OVERLAY_PAGE);
  assign overlay    = (r_mode != MODE_NORMAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_NORMAL;
    else        r_mode <= w_mode_nxt;
  end

  // NOTE: every signal assigned here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_mode_nxt = r_mode;
    w_routed   = 1'b0;
    unique case (r_mode)
      MODE_NORMAL: begin
        if (!nmi_n) w_mode_nxt = MODE_ARMED;
      end
      MODE_ARMED: begin
        w_routed = w_page_hit && r_rw_s2 && is_vector_offset(cpu_addr[7:0]);
        if (w_rise && w_page_hit && r_rw_s2 && (cpu_addr[7:0] == VECTOR_OFFSET))
          w_mode_nxt = MODE_OVERLAY;
      end
      MODE_OVERLAY: begin
        w_routed = w_page_hit;
        // Leaving the overlay: fetching code outside the page.
        if (w_rise && r_sync_s2 && !w_page_hit) w_mode_nxt = MODE_NORMAL;
      end
      default: w_mode_nxt = MODE_NORMAL;
    endcase
  end

  // Access sequencer; a phi2 rise always restarts it, cutting any hold short.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_csp_nxt   = 1'b0;
    w_write_nxt = 1'b0;
    w_oe_nxt    = data_oe;
    w_hold_nxt  = r_hold_cnt;
    w_latch     = 1'b0;
    w_cap_rdata = 1'b0;
    w_cap_wdata = 1'b0;
    if (w_rise) begin
      w_latch  = w_routed;
      w_oe_nxt = 1'b0;
      if (!w_routed) begin
        w_acc_nxt = ACC_IDLE;
      end else if (r_rw_s2) begin
        w_acc_nxt = ACC_STROBE;
        w_csp_nxt = ~csP;
      end else begin
        w_acc_nxt = ACC_WRITE;
      end
    end else begin
      unique case (r_acc)
        ACC_IDLE:    w_acc_nxt = ACC_IDLE;
        ACC_STROBE:  w_acc_nxt = ACC_CAPTURE;
        ACC_CAPTURE: begin
          w_cap_rdata = 1'b1;
          w_oe_nxt    = 1'b1;
          w_acc_nxt   = ACC_DRIVE;
        end
        ACC_DRIVE: begin
          if (w_fall) begin
            if (HOLD_CYCLES == 0) begin
              w_oe_nxt  = 1'b0;
              w_acc_nxt = ACC_IDLE;
            end else begin
              w_hold_nxt = HOLD_W'(1);
              w_acc_nxt  = ACC_HOLD;
            end
          end
        end
        ACC_HOLD: begin
          if (r_hold_cnt >= HOLD_LIM) begin
            w_oe_nxt  = 1'b0;
            w_acc_nxt = ACC_IDLE;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
        ACC_WRITE: begin
          if (w_fall) begin
            w_csp_nxt   = ~csP;
            w_write_nxt = 1'b1;
            w_cap_wdata = 1'b1;
            w_acc_nxt   = ACC_IDLE;
          end
        end
        default: w_acc_nxt = ACC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= ACC_IDLE;
      r_hold_cnt <= '0;
      r_din      <= 8'h00;
      A          <= 8'h00;
      csP        <= 1'b0;
      write      <= 1'b0;
      ctrl_wdata <= 8'h00;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_hold_cnt <= w_hold_nxt;
      csP        <= w_csp_nxt;
      write      <= w_write_nxt;
      data_oe    <= w_oe_nxt;
      if (r_phi2_s2)   r_din      <= cpu_data_in;
      if (w_latch)     A          <= cpu_addr[7:0];
      if (w_cap_rdata) data_out   <= ctrl_rdata;
      if (w_cap_wdata) ctrl_wdata <= r_din;
    end
  end

endmodule
